// File: rtl/icache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_pkg : shared types and widths for the I-cache refill control  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        RESUME = 2'd2
    } state_t;

    localparam int LINE_WORDS_DFLT = 4;
    localparam int OFFSET_W        = $clog2(LINE_WORDS_DFLT * 4);
    localparam int WCNT_W          = $clog2(LINE_WORDS_DFLT);

endpackage : icache_pkg
`default_nettype wire

// File: rtl/refill_word_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | refill_word_counter : word index within the line being refilled      |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module refill_word_counter #(
    parameter int CNT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count,
    output logic                last
);

    logic [CNT_BITS-1:0] r_count;

    // The line length is a power of two, so the last increment wraps to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CNT_BITS'(1);
        end
    end

    assign count = r_count;
    assign last  = &r_count;

endmodule : refill_word_counter
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_refill_ctrl : stalls fetch on a miss and refills one line     |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DFLT,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              fetchValid,
    input  logic [ADDR_W-1:0] fetchAddr,
    input  logic              hit,
    output logic              stall,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic              cacheWe,
    output logic [ADDR_W-1:0] cacheWAddr,
    output logic [DATA_W-1:0] cacheWData,
    output logic              cacheTagWe,
    output logic              busy,
    output logic [CNT_W-1:0]  missCount
);

    localparam int c_wcnt_w   = $clog2(LINE_WORDS);
    localparam int c_offset_w = c_wcnt_w + (OFFSET_W - WCNT_W);
    localparam logic [ADDR_W-1:0] c_line_mask =
        ~((ADDR_W'(1) << c_offset_w) - ADDR_W'(1));

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_line_addr;
    logic [CNT_W-1:0]    r_miss_count;
    logic                r_out_en;
    logic                w_accept;
    logic                w_inc;
    logic                w_last;
    logic [c_wcnt_w-1:0] w_word_cnt;
    logic [ADDR_W-1:0]   w_word_addr;

    refill_word_counter #(
        .CNT_BITS (c_wcnt_w)
    ) u_word_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .clear (w_accept),
        .inc   (w_inc),
        .count (w_word_cnt),
        .last  (w_last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_line_addr  <= '0;
            r_miss_count <= '0;
            r_out_en     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_out_en <= 1'b1;
            if (w_accept) begin
                r_line_addr <= fetchAddr & c_line_mask;
                if (r_miss_count != {CNT_W{1'b1}}) begin
                    r_miss_count <= r_miss_count + CNT_W'(1);
                end
            end
        end
    end

    // No miss is accepted in the first cycle after reset so every output stays low.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_inc      = 1'b0;
        stall      = 1'b0;
        memReq     = 1'b0;
        cacheWe    = 1'b0;
        cacheTagWe = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_out_en && fetchValid && !hit) begin
                    stall    = 1'b1;
                    w_accept = 1'b1;
                    w_next   = FILL;
                end
            end
            FILL: begin
                stall  = 1'b1;
                memReq = 1'b1;
                if (memAck) begin
                    cacheWe = 1'b1;
                    w_inc   = 1'b1;
                    if (w_last) begin
                        cacheTagWe = 1'b1;
                        w_next     = RESUME;
                    end
                end
            end
            RESUME: begin
                stall  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_word_addr = r_line_addr + (ADDR_W'(w_word_cnt) << 2);
    assign memAddr     = memReq  ? w_word_addr : '0;
    assign cacheWAddr  = cacheWe ? w_word_addr : '0;
    assign cacheWData  = cacheWe ? memRData    : '0;
    assign busy        = (r_state != IDLE);
    assign missCount   = r_miss_count;

endmodule : icache_refill_ctrl
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_icache_refill_ctrl : directed bench with a line-level refill model|
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_icache_refill_ctrl;

    localparam int LW = 4;

    logic        Clk;
    logic        Reset;
    logic        fetchValid;
    logic [31:0] fetchAddr;
    logic        hit;
    logic        stall;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRData;
    logic        cacheWe;
    logic [31:0] cacheWAddr;
    logic [31:0] cacheWData;
    logic        cacheTagWe;
    logic        busy;
    logic [15:0] missCount;

    icache_refill_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .fetchValid (fetchValid),
        .fetchAddr  (fetchAddr),
        .hit        (hit),
        .stall      (stall),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memRData   (memRData),
        .cacheWe    (cacheWe),
        .cacheWAddr (cacheWAddr),
        .cacheWData (cacheWData),
        .cacheTagWe (cacheTagWe),
        .busy       (busy),
        .missCount  (missCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks;
    int n_errors;

    // Model: a pending line is a queue of word addresses still to be fetched.
    logic [31:0] m_q[$];
    bit          m_resume;
    bit          m_armed;
    logic [15:0] m_miss;

    logic        obs_stall, obs_req, obs_we, obs_tag;
    logic [31:0] obs_maddr, obs_waddr;

    int          stall_cyc, nwe, ntag, nreq;
    logic [31:0] we_addr [16];
    logic [31:0] req_addr[16];
    logic [31:0] tag_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic        e_stall, e_req, e_we, e_tag, e_busy, miss;
        logic [31:0] e_maddr, e_waddr, e_wdata, base;
        e_stall = 0; e_req = 0; e_we = 0; e_tag = 0; e_busy = 0;
        e_maddr = 0; e_waddr = 0; e_wdata = 0;
        obs_stall = stall; obs_req = memReq; obs_we = cacheWe; obs_tag = cacheTagWe;
        obs_maddr = memAddr; obs_waddr = cacheWAddr;
        if (Reset) begin
            m_q.delete();
            m_resume = 0;
            m_armed  = 0;
            m_miss   = 16'h0;
        end
        if (!Reset && m_q.size() > 0) begin
            e_stall = 1; e_req = 1; e_busy = 1; e_maddr = m_q[0];
            if (memAck) begin
                e_we = 1; e_waddr = m_q[0]; e_wdata = memRData;
                e_tag = (m_q.size() == 1);
            end
        end else if (!Reset && m_resume) begin
            e_stall = 1; e_busy = 1;
        end else if (!Reset) begin
            e_stall = m_armed && fetchValid && !hit;
        end
        chk("stall",      32'(stall),      32'(e_stall));
        chk("memReq",     32'(memReq),     32'(e_req));
        chk("memAddr",    memAddr,         e_maddr);
        chk("cacheWe",    32'(cacheWe),    32'(e_we));
        chk("cacheWAddr", cacheWAddr,      e_waddr);
        chk("cacheWData", cacheWData,      e_wdata);
        chk("cacheTagWe", 32'(cacheTagWe), 32'(e_tag));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("missCount",  32'(missCount),  32'(m_miss));
        if (!Reset) begin
            if (m_q.size() > 0) begin
                if (memAck) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_resume = 1;
                end
            end else if (m_resume) begin
                m_resume = 0;
            end else begin
                miss = m_armed && fetchValid && !hit;
                if (miss) begin
                    base = fetchAddr & ~32'(LW * 4 - 1);
                    for (int i = 0; i < LW; i++) m_q.push_back(base + 32'(4 * i));
                    if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
                end
            end
            m_armed = 1;
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        model_check();
        @(posedge Clk);
        #1;
    endtask

    task automatic record();
        if (obs_stall) stall_cyc++;
        if (obs_we && nwe < 16) begin we_addr[nwe] = obs_waddr; nwe++; end
        if (obs_tag) begin ntag++; tag_addr = obs_waddr; end
        if (obs_req && nreq < 16) begin req_addr[nreq] = obs_maddr; nreq++; end
    endtask

    task automatic run_miss(input logic [31:0] addr, input int waits);
        int k;
        bit done;
        stall_cyc = 0; nwe = 0; ntag = 0; nreq = 0; tag_addr = 0;
        fetchValid = 1; hit = 0; fetchAddr = addr; memAck = 0; memRData = $urandom;
        tick();
        record();
        hit = 1; k = 0; done = 0;
        for (int g = 0; g < 400 && !done; g++) begin
            memAck   = ((k % (waits + 1)) == waits);
            memRData = $urandom;
            tick();
            record();
            if (!obs_stall) done = 1;
            k++;
        end
        chk("refill_completes", 32'(done), 32'd1);
        memAck = 0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_resume = 0; m_armed = 0; m_miss = 0;
        Reset = 1; fetchValid = 0; fetchAddr = 0; hit = 0; memAck = 0; memRData = 0;
        #1;
        repeat (3) tick();
        Reset = 0; fetchValid = 1; hit = 1;
        repeat (3) tick();
        chk("post_rst_stall",  32'(stall),     32'd0);
        chk("post_rst_memReq", 32'(memReq),    32'd0);
        chk("post_rst_count",  32'(missCount), 32'd0);

        // Single-cycle-ack refill of the line holding 0x48
        run_miss(32'h0000_0048, 0);
        chk("fast_stall_cycles", 32'(stall_cyc), 32'd6);
        chk("fast_nwe",          32'(nwe),       32'd4);
        chk("fast_wa0",          we_addr[0],     32'h40);
        chk("fast_wa1",          we_addr[1],     32'h44);
        chk("fast_wa2",          we_addr[2],     32'h48);
        chk("fast_wa3",          we_addr[3],     32'h4C);
        chk("fast_ntag",         32'(ntag),      32'd1);
        chk("fast_tag_addr",     tag_addr,       32'h4C);
        chk("fast_count",        32'(missCount), 32'd1);

        // Three wait cycles before each ack
        run_miss(32'h0000_0100, 3);
        chk("slow_stall_cycles", 32'(stall_cyc), 32'd18);
        chk("slow_req0",         req_addr[0],    32'h100);
        chk("slow_req3",         req_addr[3],    32'h100);
        chk("slow_req4",         req_addr[4],    32'h104);
        chk("slow_tag_addr",     tag_addr,       32'h10C);
        chk("slow_count",        32'(missCount), 32'd2);

        // Reset with two words already written
        fetchValid = 1; hit = 0; fetchAddr = 32'h200; memAck = 0;
        tick();
        hit = 1; memAck = 1;
        tick();
        tick();
        chk("pre_rst_memReq", 32'(memReq),  32'd1);
        chk("pre_rst_addr",   memAddr,      32'h208);
        Reset = 1; memAck = 0;
        #1;
        chk("mid_rst_memReq", 32'(memReq),     32'd0);
        chk("mid_rst_stall",  32'(stall),      32'd0);
        chk("mid_rst_tag",    32'(cacheTagWe), 32'd0);
        chk("mid_rst_busy",   32'(busy),       32'd0);
        tick();
        tick();
        Reset = 0; fetchValid = 0; hit = 0;
        tick();
        tick();
        run_miss(32'h0000_0200, 0);
        chk("rerefill_wa0",   we_addr[0],     32'h200);
        chk("rerefill_nwe",   32'(nwe),       32'd4);
        chk("rerefill_tag",   tag_addr,       32'h20C);
        chk("rerefill_count", 32'(missCount), 32'd1);

        // Spurious acks and no valid lookup
        fetchValid = 0; hit = 0; memAck = 1;
        repeat (3) tick();
        hit = 1;
        repeat (2) tick();
        memAck = 0;
        chk("idle_count", 32'(missCount), 32'd1);
        chk("idle_busy",  32'(busy),      32'd0);

        // Saturation of the miss counter
        force dut.r_miss_count = 16'hFFFE;
        #1;
        release dut.r_miss_count;
        m_miss = 16'hFFFE;
        chk("preset_count", 32'(missCount), 32'h0000_FFFE);
        run_miss(32'h0000_0300, 0);
        chk("sat_count1", 32'(missCount), 32'h0000_FFFF);
        run_miss(32'hFFFF_FFF8, 0);
        chk("top_wa0",    we_addr[0],     32'hFFFF_FFF0);
        chk("top_wa3",    we_addr[3],     32'hFFFF_FFFC);
        chk("sat_count2", 32'(missCount), 32'h0000_FFFF);
        run_miss(32'h0000_1004, 2);
        chk("sat_count3", 32'(missCount), 32'h0000_FFFF);
        chk("w2_stall",   32'(stall_cyc), 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_icache_refill_ctrl
`default_nettype wire
